// File: rtl/muldiv_iter_pkg.sv
// Shared encodings for the iterative M-extension unit: funct3 codes, FSM states, latched op context.
package muldiv_iter_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // neg_q negates the product or quotient; neg_r negates the remainder
    typedef struct packed {
        logic [2:0] op;
        logic       neg_q;
        logic       neg_r;
    } ctx_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one bit per step.
module muldiv_iter_core #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            step,
    input  logic            div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            last_c,
    output logic [XLEN-1:0] hi_c,
    output logic [XLEN-1:0] lo_c
);

    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN:0]    sum;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    // hi:lo is the product (mul) or remainder:quotient (div); hi_c/lo_c are the post-step values
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        hi_c    = hi_q;
        lo_c    = lo_q;
        if (step) begin
            if (div) begin
                if (!diff[XLEN]) begin
                    hi_c = diff[XLEN-1:0];
                    lo_c = {lo_q[XLEN-2:0], 1'b1};
                end else begin
                    hi_c = shifted[XLEN-1:0];
                    lo_c = {lo_q[XLEN-2:0], 1'b0};
                end
            end else begin
                hi_c = sum[XLEN:1];
                lo_c = {sum[0], lo_q[XLEN-1:1]};
            end
        end
        last_c = step && (cnt_q == CNT_W'(XLEN - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (start) begin
            hi_q  <= '0;
            lo_q  <= a;
            b_q   <= b;
            cnt_q <= '0;
        end else begin
            hi_q <= hi_c;
            lo_q <= lo_c;
            if (step) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Multi-cycle RISC-V M-extension unit with start/busy/done handshake and kill.
// Optional MULDIV_FAST_MUL_EN: multiplies finish in one cycle via the native operator.
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic            KILL,
    input  logic [2:0]      OP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    if (XLEN < 8 || XLEN > 64) begin : g_bad_xlen
        $error("muldiv_iter: XLEN must be in 8..64");
    end

    localparam int unsigned DW = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    state_t          state_q, state_d;
    ctx_t            ctx_q, ctx_d;
    logic            signed1, signed2, sign1, sign2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;
    logic            core_start, core_step, core_last;
    logic [XLEN-1:0] core_hi, core_lo;
    logic [DW-1:0]   prod, prod_fix;
    logic [XLEN-1:0] quot_fix, rem_fix, calc_res;
    logic            res_load;
    logic [XLEN-1:0] res_d;

    // Operand preparation: sign flags, magnitudes and divide special cases from live inputs
    always_comb begin
        signed1  = (OP == F3_MULH) || (OP == F3_MULHSU) || (OP == F3_DIV) || (OP == F3_REM);
        signed2  = (OP == F3_MULH) || (OP == F3_DIV) || (OP == F3_REM);
        sign1    = signed1 && DATA1[XLEN-1];
        sign2    = signed2 && DATA2[XLEN-1];
        mag1     = sign1 ? (~DATA1) + XLEN'(1) : DATA1;
        mag2     = sign2 ? (~DATA2) + XLEN'(1) : DATA2;
        div_zero = is_div(OP) && (DATA2 == '0);
        div_ovf  = ((OP == F3_DIV) || (OP == F3_REM)) && (DATA1 == MIN_INT) && (DATA2 == ALL_ONES);
        if (div_zero) begin
            special_res = OP[1] ? DATA1 : ALL_ONES;
        end else begin
            special_res = OP[1] ? '0 : MIN_INT;
        end
        ctx_d.op    = OP;
        ctx_d.neg_q = sign1 ^ sign2;
        ctx_d.neg_r = sign1;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [DW-1:0] fast_prod;

    always_comb begin
        fast_prod = {{XLEN{sign1}}, DATA1} * {{XLEN{sign2}}, DATA2};
        fast_hit  = !is_div(OP);
        fast_res  = (OP == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[DW-1:XLEN];
    end
`else
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
    end
`endif

    muldiv_iter_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (CLK),
        .rst    (RESET),
        .start  (core_start),
        .step   (core_step),
        .div    (is_div(ctx_q.op)),
        .a      (mag1),
        .b      (mag2),
        .last_c (core_last),
        .hi_c   (core_hi),
        .lo_c   (core_lo)
    );

    // Sign fixup and result select on the core's post-final-step values
    always_comb begin
        prod     = {core_hi, core_lo};
        prod_fix = ctx_q.neg_q ? (~prod) + DW'(1) : prod;
        quot_fix = ctx_q.neg_q ? (~core_lo) + XLEN'(1) : core_lo;
        rem_fix  = ctx_q.neg_r ? (~core_hi) + XLEN'(1) : core_hi;
        case (ctx_q.op)
            F3_MUL:                      calc_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: calc_res = prod_fix[DW-1:XLEN];
            F3_DIV, F3_DIVU:             calc_res = quot_fix;
            default:                     calc_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        core_step  = 1'b0;
        res_load   = 1'b0;
        res_d      = calc_res;
        case (state_q)
            ST_IDLE: begin
                if (START && !KILL) begin
                    if (div_zero || div_ovf) begin
                        state_d  = ST_FIN;
                        res_load = 1'b1;
                        res_d    = special_res;
                    end else if (fast_hit) begin
                        state_d  = ST_FIN;
                        res_load = 1'b1;
                        res_d    = fast_res;
                    end else begin
                        state_d    = ST_CALC;
                        core_start = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                if (KILL) begin
                    state_d = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    if (core_last) begin
                        state_d  = ST_FIN;
                        res_load = 1'b1;
                    end
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ctx_q   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RESULT  <= '0;
        end else begin
            state_q <= state_d;
            BUSY    <= (state_d != ST_IDLE);
            DONE    <= (state_d == ST_FIN);
            if (state_q == ST_IDLE && START && !KILL) begin
                ctx_q <= ctx_d;
            end
            if (res_load) begin
                RESULT <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter (XLEN=32): directed spec cases, handshake/kill/reset, random ops vs a model.
module tb_muldiv_iter;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   ecnt       = 0;
    int   start_edge = 0;

    muldiv_iter #(.XLEN(32)) dut (
        .CLK    (clk),
        .RESET  (rst),
        .START  (start),
        .KILL   (kill),
        .OP     (op),
        .DATA1  (data1),
        .DATA2  (data2),
        .BUSY   (busy),
        .DONE   (done),
        .RESULT (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb_ = longint'($signed(b));
        longint          ub = longint'({32'b0, b});
        longint unsigned ua = {32'b0, a};
        longint          p;
        longint unsigned pu;
        int              ia = a;
        int              ib = b;
        logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            OP_MUL:    begin p = sa * sb_; return p[31:0]; end
            OP_MULH:   begin p = sa * sb_; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub;  return p[63:32]; end
            OP_MULHU:  begin pu = ua * longint'(ub); return pu[63:32]; end
            OP_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (!o[2]) return MUL_LAT;
        if (b == 0) return 1;
        if ((o == OP_DIV || o == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Scoreboard: every DONE pops one expectation and checks value and latency
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                e = sb.pop_front();
                check("result", 64'(result), 64'(e.res));
                check("latency", 64'(ecnt - start_edge), 64'(e.lat));
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; data1 = a; data2 = b; start = 1'b1;
        start_edge = ecnt;
    endtask

    task automatic wait_cycle(input int c);
        for (int i = 0; i < 100 && (ecnt - start_edge) < c; i++) @(negedge clk);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        e.res = exp;
        e.lat = lat_of(o, a, b);
        issue(o, a, b);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_cycle1", 64'(busy), 64'(1));
        wait_drain();
        @(negedge clk);
        check("busy_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        exp_t e;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; data1 = '0; data2 = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        rst = 1'b0;

        do_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        do_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        do_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        do_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        do_op(OP_DIVU,   32'h8000_0000,  32'd3,         32'h2AAA_AAAA);
        do_op(OP_REMU,   32'h8000_0000,  32'd3,         32'h0000_0002);
        do_op(OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF);
        do_op(OP_REM,    32'd5,          32'd0,         32'd5);
        do_op(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF);
        do_op(OP_REMU,   32'd5,          32'd0,         32'd5);
        do_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        do_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);

        // Second START while busy must be ignored and not queued
        issue(OP_DIVU, 32'd100, 32'd7);
        e.res = 32'd14; e.lat = 33;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_cycle(5);
        op = OP_DIVU; data1 = 32'd50; data2 = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignore", 64'(busy), 64'(1));
        wait_drain();
        repeat (40) @(negedge clk);
        check("ignored_start_idle", 64'(busy), 64'(0));

        do_op(OP_REMU, 32'h8000_0000, 32'd3, 32'd2);

        // KILL mid-CALC: back to idle, no DONE, RESULT held
        issue(OP_DIVU, 32'd1000, 32'd7);
        @(negedge clk);
        start = 1'b0;
        wait_cycle(10);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_busy", 64'(busy), 64'(0));
        check("kill_result", 64'(result), 64'(2));
        repeat (40) @(negedge clk);
        check("kill_result_held", 64'(result), 64'(2));

        // KILL together with START in IDLE: not accepted
        issue(OP_DIVU, 32'd9, 32'd3);
        kill = 1'b1;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("kill_start_busy", 64'(busy), 64'(0));
        repeat (40) @(negedge clk);
        check("kill_start_result", 64'(result), 64'(2));

        do_op(OP_DIVU, 32'd100, 32'd7, 32'd14);

        for (int k = 0; k < 24; k++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            do_op(ro, ra, rb, ref_md(ro, ra, rb));
        end

        // Reset mid-CALC clears outputs asynchronously
        issue(OP_DIVU, 32'd1000, 32'd7);
        @(negedge clk);
        start = 1'b0;
        wait_cycle(10);
        check("pre_reset_busy", 64'(busy), 64'(1));
        rst = 1'b1;
        #1;
        check("async_reset_busy", 64'(busy), 64'(0));
        check("async_reset_done", 64'(done), 64'(0));
        check("async_reset_result", 64'(result), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_reset_idle", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
